// File: rtl/shiftreg_arb.sv
// Two-requester round-robin arbiter feeding an 8-bit MSB-first serialiser with an idle gap after each frame.
// Optional even-parity trailer bit is enabled by defining SHIFTREG_ARB_PARITY_EN.
module shiftreg_arb #(
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_data0,
    input  logic [7:0] i_data1,
    input  logic       i_vld0,
    input  logic       i_vld1,
    output logic       o_rdy0,
    output logic       o_rdy1,
    output logic       o_out,
    output logic       o_out_vld,
    output logic       o_src,
    output logic       o_busy
);

`ifdef SHIFTREG_ARB_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2, PAR = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_t;
`endif

    localparam logic [3:0] GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    state_t      post_frame;
    logic [7:0]  sreg_q, sreg_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic        ptr_q, ptr_d;
    logic        src_q, src_d;
`ifdef SHIFTREG_ARB_PARITY_EN
    logic        par_q, par_d;
`endif

    logic grant0, grant1;

    // Ready is combinational from valid; it is forced low while reset is held.
    assign grant0 = i_vld0 & (~i_vld1 | ~ptr_q);
    assign grant1 = i_vld1 & (~i_vld0 | ptr_q);
    assign o_rdy0 = (state_q == IDLE) & ~rst & grant0;
    assign o_rdy1 = (state_q == IDLE) & ~rst & grant1;
    assign o_busy = (state_q != IDLE);
    assign o_src  = src_q;

    assign post_frame = (GAP_CYCLES > 0) ? GAP : IDLE;

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d   = state_q;
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        ptr_d     = ptr_q;
        src_d     = src_q;
`ifdef SHIFTREG_ARB_PARITY_EN
        par_d     = par_q;
`endif
        o_out     = 1'b0;
        o_out_vld = 1'b0;

        case (state_q)
            IDLE: begin
                if (o_rdy0 | o_rdy1) begin
                    sreg_d    = o_rdy1 ? i_data1 : i_data0;
                    src_d     = o_rdy1;
                    ptr_d     = ~o_rdy1;
                    bit_cnt_d = 3'd0;
`ifdef SHIFTREG_ARB_PARITY_EN
                    par_d     = o_rdy1 ? ^i_data1 : ^i_data0;
`endif
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                o_out_vld = 1'b1;
                o_out     = sreg_q[7];
                sreg_d    = {sreg_q[6:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    gap_cnt_d = 4'd0;
`ifdef SHIFTREG_ARB_PARITY_EN
                    state_d   = PAR;
`else
                    state_d   = post_frame;
`endif
                end
            end
`ifdef SHIFTREG_ARB_PARITY_EN
            PAR: begin
                o_out_vld = 1'b1;
                o_out     = par_q;
                gap_cnt_d = 4'd0;
                state_d   = post_frame;
            end
`endif
            GAP: begin
                gap_cnt_d = gap_cnt_q + 4'd1;
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sreg_q    <= 8'd0;
            bit_cnt_q <= 3'd0;
            gap_cnt_q <= 4'd0;
            ptr_q     <= 1'b0;
            src_q     <= 1'b0;
`ifdef SHIFTREG_ARB_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            ptr_q     <= ptr_d;
            src_q     <= src_d;
`ifdef SHIFTREG_ARB_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

endmodule
